// File: rtl/quad_dir_if.sv
// Quadrature encoder pins plus decoded step/error outputs.
// The encoder side drives the channels; the decoder side returns pulses and status.
interface quad_dir_if;
  logic ch_a;
  logic ch_b;
  logic up;
  logic down;
  logic err;
  logic tracking;

  modport master (
    output ch_a,
    output ch_b,
    input  up,
    input  down,
    input  err,
    input  tracking
  );

  modport slave (
    input  ch_a,
    input  ch_b,
    output up,
    output down,
    output err,
    output tracking
  );
endinterface

// File: rtl/quad_dir_decoder.sv
// Quadrature decoder: synchronises and glitch-filters channels A/B, then turns
// phase transitions into single-cycle up/down pulses, or err on an illegal jump.
module quad_dir_decoder #(
  parameter int unsigned FILTER_LEN = 4,
  parameter int unsigned CNT_W      = 3
) (
  input  logic       clk,
  input  logic       reset,
  quad_dir_if.slave  bus
);

  typedef enum logic {StInit, StTrack} state_e;

  // Bit 1 carries channel A, bit 0 channel B, so the filtered vector is the phase.
  logic [1:0]            sync1_q;
  logic [1:0]            s_q;
  logic [1:0]            f_q, f_d;
  logic [1:0][CNT_W-1:0] cnt_q, cnt_d;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [1:0]       prev_q, prev_d;
  logic             up_q, up_d;
  logic             down_q, down_d;
  logic             err_q, err_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      s_q     <= '0;
    end else begin
      sync1_q <= {bus.ch_a, bus.ch_b};
      s_q     <= sync1_q;
    end
  end

  // A change is accepted only after FILTER_LEN consecutive differing samples.
  always_comb begin
    f_d   = f_q;
    cnt_d = cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (s_q[i] == f_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_W'(FILTER_LEN - 1)) begin
        f_d[i]   = s_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      f_q   <= '0;
      cnt_q <= '0;
    end else begin
      f_q   <= f_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    prev_d  = prev_q;
    up_d    = 1'b0;
    down_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      StInit: begin
        // Wait long enough for a steady level to reach the filters before sampling it.
        if (timer_q == CNT_W'(FILTER_LEN + 2)) begin
          prev_d  = f_q;
          state_d = StTrack;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      StTrack: begin
        prev_d = f_q;
        case ({prev_q, f_q})
          4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: up_d   = 1'b1;
          4'b01_00, 4'b11_01, 4'b10_11, 4'b00_10: down_d = 1'b1;
          default: ;
        endcase
        err_d = &(prev_q ^ f_q);
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StInit;
      timer_q <= '0;
      prev_q  <= '0;
      up_q    <= 1'b0;
      down_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      prev_q  <= prev_d;
      up_q    <= up_d;
      down_q  <= down_d;
      err_q   <= err_d;
    end
  end

  assign bus.up       = up_q;
  assign bus.down     = down_q;
  assign bus.err      = err_q;
  assign bus.tracking = (state_q == StTrack);

endmodule

// File: tb/tb_quad_dir_decoder.sv
// Bench for quad_dir_decoder: directed segment table, hand sequences for glitch and
// reset corner cases, and random pin activity checked cycle by cycle against a model.
module tb_quad_dir_decoder;
  localparam int unsigned N = 4;

  logic clk = 1'b0;
  logic reset;

  quad_dir_if bus();

  quad_dir_decoder #(.FILTER_LEN(N), .CNT_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: pin history windows and the phase seen on previous edges.
  bit       ha[$];
  bit       hb[$];
  bit       mfa, mfb;
  int       edge_n;
  bit [1:0] p_last;
  bit       m_up, m_down, m_err, m_trk;

  int seg_up, seg_down, seg_err;
  int ctr;

  typedef struct {
    logic a;
    logic b;
    int   hold;
    int   n_up;
    int   n_down;
    int   n_err;
  } seg_t;

  seg_t tbl[11];

  function automatic int gidx(input bit [1:0] p);
    case (p)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at edge %0d", name, act, exp, edge_n);
    end
  endtask

  // Filtered level flips once the last N synchronised samples all disagree with it;
  // the synchroniser makes the sample seen at edge e the pin value of edge e-2.
  task automatic model_step(input bit a, input bit b, input bit r);
    bit [1:0] p_before;
    bit       all_a, all_b;
    int       d;
    if (r) begin
      ha.delete();
      hb.delete();
      for (int i = 0; i < N + 2; i++) begin
        ha.push_back(1'b0);
        hb.push_back(1'b0);
      end
      mfa    = 1'b0;
      mfb    = 1'b0;
      edge_n = 0;
      p_last = 2'b00;
      m_up   = 1'b0;
      m_down = 1'b0;
      m_err  = 1'b0;
      m_trk  = 1'b0;
    end else begin
      edge_n++;
      ha.push_front(a);
      void'(ha.pop_back());
      hb.push_front(b);
      void'(hb.pop_back());
      p_before = {mfa, mfb};
      all_a = 1'b1;
      all_b = 1'b1;
      for (int j = 2; j < N + 2; j++) begin
        if (ha[j] == mfa) all_a = 1'b0;
        if (hb[j] == mfb) all_b = 1'b0;
      end
      if (all_a) mfa = ~mfa;
      if (all_b) mfb = ~mfb;
      m_trk = (edge_n >= N + 3);
      d = (gidx(p_before) - gidx(p_last) + 4) % 4;
      if (edge_n >= N + 4) begin
        m_up   = (d == 1);
        m_down = (d == 3);
        m_err  = (d == 2);
      end else begin
        m_up   = 1'b0;
        m_down = 1'b0;
        m_err  = 1'b0;
      end
      p_last = p_before;
    end
  endtask

  // Called at a negedge; drives pins, steps model at posedge, samples #1 later.
  task automatic tick(input logic a, input logic b, input logic r);
    bus.ch_a = a;
    bus.ch_b = b;
    reset    = r;
    @(posedge clk);
    model_step(a, b, r);
    #1;
    check("cycle", {28'd0, bus.up, bus.down, bus.err, bus.tracking},
          {28'd0, m_up, m_down, m_err, m_trk});
    check("onehot", 32'($countones({bus.up, bus.down, bus.err}) <= 1), 32'd1);
    seg_up   += int'(bus.up);
    seg_down += int'(bus.down);
    seg_err  += int'(bus.err);
    ctr       = (ctr + int'(bus.up) - int'(bus.down) + 16) % 16;
    @(negedge clk);
  endtask

  task automatic clear_seg();
    seg_up   = 0;
    seg_down = 0;
    seg_err  = 0;
  endtask

  task automatic check_seg(input string name, input int eu, input int ed, input int ee);
    check({name, "_up"}, seg_up, eu);
    check({name, "_down"}, seg_down, ed);
    check({name, "_err"}, seg_err, ee);
  endtask

  initial begin
    int rise_at;
    logic ra, rb;
    int hold;

    tbl[0]  = '{1'b0, 1'b1, 10, 1, 0, 0};
    tbl[1]  = '{1'b1, 1'b1, 10, 1, 0, 0};
    tbl[2]  = '{1'b1, 1'b0, 10, 1, 0, 0};
    tbl[3]  = '{1'b0, 1'b0, 10, 1, 0, 0};
    tbl[4]  = '{1'b1, 1'b0, 10, 0, 1, 0};
    tbl[5]  = '{1'b1, 1'b1, 10, 0, 1, 0};
    tbl[6]  = '{1'b0, 1'b1, 10, 0, 1, 0};
    tbl[7]  = '{1'b0, 1'b0, 10, 0, 1, 0};
    tbl[8]  = '{1'b1, 1'b1, 10, 0, 0, 1};
    tbl[9]  = '{1'b1, 1'b0, 10, 1, 0, 0};
    tbl[10] = '{1'b0, 1'b0, 10, 1, 0, 0};

    bus.ch_a = 1'b0;
    bus.ch_b = 1'b0;
    reset    = 1'b1;
    ctr      = 0;
    clear_seg();
    @(negedge clk);

    // Reset, steady 00, tracking rise timing.
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    check("reset_trk", bus.tracking, 1'b0);
    clear_seg();
    rise_at = 0;
    for (int i = 1; i <= 20; i++) begin
      tick(1'b0, 1'b0, 1'b0);
      if (bus.tracking === 1'b1 && rise_at == 0) rise_at = i;
    end
    check("trk_rise", rise_at, N + 3);
    check_seg("steady", 0, 0, 0);

    // Forward, reverse, illegal jump rows.
    for (int r = 0; r < 11; r++) begin
      if (r == 0 || r == 4) ctr = (r == 0) ? 0 : ctr;
      clear_seg();
      repeat (tbl[r].hold) tick(tbl[r].a, tbl[r].b, 1'b0);
      check($sformatf("row%0d", r), {seg_up[7:0], seg_down[7:0], seg_err[7:0]},
            {tbl[r].n_up[7:0], tbl[r].n_down[7:0], tbl[r].n_err[7:0]});
      if (r == 3) check("ctr_fwd", ctr, 4);
      if (r == 7) check("ctr_rev", ctr, 0);
    end

    // Glitch of N-1 cycles ignored; exactly N cycles accepted (down then up).
    clear_seg();
    repeat (N - 1) tick(1'b1, 1'b0, 1'b0);
    repeat (10) tick(1'b0, 1'b0, 1'b0);
    check_seg("glitch", 0, 0, 0);
    clear_seg();
    repeat (N) tick(1'b1, 1'b0, 1'b0);
    repeat (12) tick(1'b0, 1'b0, 1'b0);
    check_seg("pulse4", 1, 1, 0);

    // Reset while a step is pending at AB=11.
    repeat (10) tick(1'b0, 1'b1, 1'b0);
    repeat (3) tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b1);
    check("midrst_out", {bus.up, bus.down, bus.err, bus.tracking}, 4'b0000);
    clear_seg();
    rise_at = 0;
    for (int i = 1; i <= 12; i++) begin
      tick(1'b1, 1'b1, 1'b0);
      if (bus.tracking === 1'b1 && rise_at == 0) rise_at = i;
    end
    check("midrst_rise", rise_at, N + 3);
    check_seg("midrst", 0, 0, 0);

    // Random pin activity with occasional resets.
    for (int k = 0; k < 70; k++) begin
      ra   = 1'($urandom_range(0, 1));
      rb   = 1'($urandom_range(0, 1));
      hold = $urandom_range(1, 12);
      if ($urandom_range(0, 24) == 0) tick(ra, rb, 1'b1);
      repeat (hold) tick(ra, rb, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
